crossbar_feeder: RTL

CROSSBAR_FEEDER -- requirements
Module: crossbar_feeder

---
 rtl/crossbar_feeder_pkg.sv | 6 +
 rtl/crossbar_feeder_if.sv | 22 ++
 rtl/crossbar_feeder_fifo.sv | 35 +++
 rtl/crossbar_feeder.sv | 62 ++++++
 4 files changed

// File: rtl/crossbar_feeder_pkg.sv
// crossbar_feeder_pkg: lane/control widths and FSM states shared with the crossbar.
package crossbar_feeder_pkg;
    localparam int LANE_W = 4;
    localparam int CTRL_W = 5;
    typedef enum logic [1:0] {IDLE, STREAM, SWEEP} state_t;
endpackage

// File: rtl/crossbar_feeder_if.sv
// crossbar_feeder_if: upstream word handshake plus registered crossbar lanes.
interface crossbar_feeder_if #(
    parameter int DW = crossbar_feeder_pkg::LANE_W,
    parameter int CW = crossbar_feeder_pkg::CTRL_W
);
    logic          s_valid;
    logic          s_ready;
    logic [4*DW-1:0] s_data;
    logic [CW-1:0] s_control;
    logic [DW-1:0] xb_in1, xb_in2, xb_in3, xb_in4;
    logic [CW-1:0] xb_control;
    logic          xb_valid;
    logic          m_ready;
    modport master (
        input  s_valid, s_data, s_control, m_ready,
        output s_ready, xb_in1, xb_in2, xb_in3, xb_in4, xb_control, xb_valid
    );
    modport slave (
        output s_valid, s_data, s_control, m_ready,
        input  s_ready, xb_in1, xb_in2, xb_in3, xb_in4, xb_control, xb_valid
    );
endinterface

// File: rtl/crossbar_feeder_fifo.sv
// crossbar_feeder_fifo: synchronous FIFO; an empty FIFO reads through its write data.
module crossbar_feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 21,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // push+pop on an empty FIFO hands the incoming word straight to the reader
    assign rd_data = empty ? wr_data : mem[rp];
    always_ff @(posedge clk)
        if (push) mem[wp] <= wr_data;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(push);
            rp <= rp + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

// File: rtl/crossbar_feeder.sv
// crossbar_feeder: queues routing words for a crossbar and can sweep every control value.
module crossbar_feeder
    import crossbar_feeder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW = LANE_W,
    parameter int CW = CTRL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    crossbar_feeder_if.master          bus,
    input  logic                       sweep_start,
    input  logic [4*DW-1:0]            sweep_data,
    output logic                       sweep_busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    state_t state, state_n;
    logic push, pop, xfer, full, empty, load, sweep_go;
    logic [CW+4*DW-1:0] head;
    crossbar_feeder_fifo #(.DEPTH(DEPTH), .W(CW+4*DW)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .wr_data({bus.s_control, bus.s_data}), .rd_data(head),
        .full(full), .empty(empty), .count(fifo_count)
    );
    assign bus.s_ready = !full && state != SWEEP && !rst;
    assign push = bus.s_valid && bus.s_ready;
    assign xfer = bus.xb_valid && bus.m_ready;
    assign load = state != SWEEP && (!bus.xb_valid || bus.m_ready) && (!empty || push);
    assign pop = load;
    assign sweep_go = state == IDLE && sweep_start && !bus.s_valid;
    assign sweep_busy = state == SWEEP;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = push ? STREAM : sweep_go ? SWEEP : IDLE;
            STREAM:  state_n = (xfer && empty && !push) ? IDLE : STREAM;
            SWEEP:   state_n = (xfer && bus.xb_control == '1) ? IDLE : SWEEP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {bus.xb_control, bus.xb_in4, bus.xb_in3, bus.xb_in2, bus.xb_in1} <= '0;
            bus.xb_valid <= 1'b0;
        end else if (load) begin
            {bus.xb_control, bus.xb_in4, bus.xb_in3, bus.xb_in2, bus.xb_in1} <= head;
            bus.xb_valid <= 1'b1;
        end else if (sweep_go) begin
            {bus.xb_in4, bus.xb_in3, bus.xb_in2, bus.xb_in1} <= sweep_data;
            bus.xb_control <= '0;
            bus.xb_valid <= 1'b1;
        end else if (state == SWEEP && xfer) begin
            // the last control value ends the sweep rather than wrapping
            if (bus.xb_control == '1) bus.xb_valid <= 1'b0;
            else bus.xb_control <= bus.xb_control + 1'b1;
        end else if (xfer) begin
            bus.xb_valid <= 1'b0;
        end
endmodule
